// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory loader.
// Loader FSM encoding, word geometry and count clamping.
package dmem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

  // Requested counts above capacity load a full memory.
  function automatic logic [14:0] clamp_count(
    input logic [14:0] req,
    input int unsigned max_words
  );
    if (32'(req) > max_words)
      return 15'(max_words);
    return req;
  endfunction

endpackage

// File: rtl/dmem_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
// Counts bytes in a word and flags the fourth one.
module word_assembler
  import dmem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);

  logic [31:0]       r_shift;
  logic [BCNT_W-1:0] r_cnt;
  logic [31:0]       w_next;
  logic              w_last;

  // New bytes enter at the top so byte 0 ends in [7:0].
  assign w_next = {i_byte, r_shift[31:8]};
  assign w_last = (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // The word is complete in the same cycle its last byte arrives.
  assign o_word     = w_next;
  assign o_complete = i_byte_en & w_last;

  // Shift register and byte counter; clear drops a partial word.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_en) begin
      r_shift <= w_next;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Streams bytes into 32-bit words and writes them to dmemory32.
// FSM, counters and address generation; outputs are registered.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] wordCount,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        busy,
  output logic        done
);

  ld_state_e   r_state;
  logic [14:0] r_count;
  logic [14:0] r_idx;
  logic        r_byte_ready;
  logic        r_mem_write;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_start_ok;
  logic [31:0] w_word;
  logic        w_complete;
  logic        w_last_word;

  assign w_accept    = byteValid & r_byte_ready;
  assign w_start_ok  = start & (r_state == ST_IDLE);
  assign w_last_word = (r_idx == 15'(r_count - 15'd1));

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_start_ok),
    .i_byte_en  (w_accept),
    .i_byte     (byteData),
    .o_word     (w_word),
    .o_complete (w_complete)
  );

  // Loader FSM with registered handshake and memory outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count <= clamp_count(wordCount, MAX_WORDS);
            r_idx   <= '0;
            r_busy  <= 1'b1;
            if (wordCount == 15'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_COLLECT;
              r_byte_ready <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_complete) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_mem_write  <= 1'b1;
            r_address    <= BASE_ADDR + (32'(r_idx) << 2);
            r_write_data <= w_word;
          end
        end
        ST_WRITE: begin
          r_mem_write <= 1'b0;
          if (w_last_word) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx        <= r_idx + 15'd1;
            r_state      <= ST_COLLECT;
            r_byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign byteReady = r_byte_ready;
  assign memWrite  = r_mem_write;
  assign address   = r_address;
  assign writeData = r_write_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
